// File: rtl/addr_alu_datapath.sv
// ============================================================================
//  Module   : addr_alu_datapath
//  Purpose  : 65C02 datapath slice - ADL/ADH address generators, PC, AHL latch
//             and 8-bit ALU. Optional BCD adjust flags under macro ALU_BCD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_alu_datapath (
  input  logic        clk,
  input  logic        RST,
  input  logic [11:0] ab_op,
  input  logic        cond,
  input  logic [7:0]  DB,
  input  logic [7:0]  REG,
  input  logic [7:0]  M,
  input  logic [4:0]  alu_op,
  input  logic        alu_ci,
  input  logic        alu_si,
  output logic [15:0] AD,
  output logic [15:0] PC,
  output logic [7:0]  alu_out,
  output logic        alu_co,
  output logic        alu_v,
  output logic        adjh,
  output logic        adjl
);

  logic [7:0] abl_q, abl_d, abh_q, abh_d;
  logic [7:0] pcl_q, pcl_d, pch_q, pch_d;
  logic [7:0] ahl_q, ahl_d;

  logic       inc_pc, ld_pc, ld_ahl, abl_ci;
  logic [3:0] abh_op, abl_op;
  logic [8:0] adl_sum;
  logic [7:0] adh;
  logic [7:0] abl_co8;
  logic [15:0] ad;

  assign inc_pc = ab_op[11];
  assign ld_pc  = ab_op[10];
  assign ld_ahl = ab_op[9];
  assign abh_op = ab_op[8:5];
  assign abl_op = ab_op[4:1];
  assign abl_ci = ab_op[0];

  always_comb begin
    adl_sum = 9'h000;
    if (abl_op[3]) begin
      adl_sum = {1'b0, pcl_q} + {1'b0, (cond ? DB : 8'h00)} + {8'h00, abl_ci};
    end else begin
      case (abl_op[2:0])
        3'b000:  adl_sum = {1'b0, pcl_q} + {8'h00, abl_ci};
        3'b001:  adl_sum = {1'b0, abl_q} + {8'h00, abl_ci};
        3'b010:  adl_sum = {1'b0, DB} + {8'h00, abl_ci};
        3'b011:  adl_sum = {1'b0, DB} + {1'b0, REG} + {8'h00, abl_ci};
        3'b100:  adl_sum = {1'b0, ahl_q} + {1'b0, REG} + {8'h00, abl_ci};
        3'b101:  adl_sum = {1'b0, REG} + {8'h00, abl_ci};
        3'b110:  adl_sum = {1'b0, ahl_q} + {8'h00, abl_ci};
        default: adl_sum = {1'b0, abl_q} + {1'b0, REG} + {8'h00, abl_ci};
      endcase
    end
  end

  assign abl_co8 = {7'b0, adl_sum[8]};

  // Branch high byte adds the sign extension of the offset held in AHL.
  always_comb begin
    case (abh_op)
      4'b0000: adh = pch_q + abl_co8;
      4'b0001: adh = abh_q + abl_co8;
      4'b0010: adh = DB + abl_co8;
      4'b0011: adh = 8'h01;
      4'b0100: adh = 8'h00;
      4'b0101: adh = 8'hFF;
      4'b0110: adh = pch_q + (cond ? {8{ahl_q[7]}} : 8'h00) + abl_co8;
      default: adh = abh_q;
    endcase
  end

  assign ad = {adh, adl_sum[7:0]};
  assign AD = ad;
  assign PC = {pch_q, pcl_q};

  always_comb begin
    abl_d = ad[7:0];
    abh_d = ad[15:8];
    ahl_d = ld_ahl ? DB : ahl_q;
    {pch_d, pcl_d} = ld_pc ? (ad + {15'b0, inc_pc}) : {pch_q, pcl_q};
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      abl_q <= 8'h00;
      abh_q <= 8'h00;
      pcl_q <= 8'h00;
      pch_q <= 8'h00;
      ahl_q <= 8'h00;
    end else begin
      abl_q <= abl_d;
      abh_q <= abh_d;
      pcl_q <= pcl_d;
      pch_q <= pch_d;
      ahl_q <= ahl_d;
    end
  end

  logic [7:0] alu_b;
  logic [8:0] add_sum, inc_sum;

  assign alu_b   = alu_op[4] ? ~M : M;
  assign add_sum = {1'b0, REG} + {1'b0, alu_b} + {8'h00, alu_ci};
  assign inc_sum = {1'b0, REG} + 9'd1;

  always_comb begin
    alu_out = REG;
    alu_co  = 1'b0;
    alu_v   = 1'b0;
    case (alu_op[3:0])
      4'b0000: begin
        alu_out = add_sum[7:0];
        alu_co  = add_sum[8];
        alu_v   = (REG[7] == alu_b[7]) && (add_sum[7] != REG[7]);
      end
      4'b0001: alu_out = REG | alu_b;
      4'b0010: alu_out = REG & alu_b;
      4'b0011: alu_out = REG ^ alu_b;
      4'b0100: begin
        alu_out = {REG[6:0], alu_si};
        alu_co  = REG[7];
      end
      4'b0101: begin
        alu_out = {alu_si, REG[7:1]};
        alu_co  = REG[0];
      end
      4'b0110: alu_out = alu_b;
      4'b1000: begin
        alu_out = inc_sum[7:0];
        alu_co  = inc_sum[8];
      end
      4'b1001: alu_out = REG + 8'hFF;
      default: alu_out = REG;
    endcase
  end

`ifdef ALU_BCD_EN
  logic [4:0] half_sum;
  logic       is_add;

  assign half_sum = {1'b0, REG[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_ci};
  assign is_add   = (alu_op[3:0] == 4'b0000);

  // Subtraction adjusts whenever a borrow occurred out of the nibble/byte.
  always_comb begin
    adjl = 1'b0;
    adjh = 1'b0;
    if (is_add) begin
      if (alu_op[4]) begin
        adjl = ~half_sum[4];
        adjh = ~add_sum[8];
      end else begin
        adjl = half_sum[4] | (add_sum[3:0] > 4'd9);
        adjh = add_sum[8] | (add_sum[7:0] > 8'h99);
      end
    end
  end
`else
  assign adjl = 1'b0;
  assign adjh = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_addr_alu_datapath.sv
// Bench for addr_alu_datapath: arithmetic reference model plus directed literal checks.
`default_nettype none

module tb_addr_alu_datapath;

  logic        clk = 1'b0;
  logic        RST;
  logic [11:0] ab_op;
  logic        cond;
  logic [7:0]  DB, REG, M;
  logic [4:0]  alu_op;
  logic        alu_ci, alu_si;
  logic [15:0] AD, PC;
  logic [7:0]  alu_out;
  logic        alu_co, alu_v, adjh, adjl;

  always #5 clk = ~clk;

  addr_alu_datapath dut (
    .clk(clk), .RST(RST), .ab_op(ab_op), .cond(cond), .DB(DB), .REG(REG), .M(M),
    .alu_op(alu_op), .alu_ci(alu_ci), .alu_si(alu_si), .AD(AD), .PC(PC),
    .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v), .adjh(adjh), .adjl(adjl)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk = 1'b0;
  int m_abl, m_abh, m_ahl, m_pc;

  function automatic logic [11:0] ab(input bit inc, input bit ld, input bit lda,
                                     input logic [3:0] hop, input logic [3:0] lop, input bit ci);
    return {inc, ld, lda, hop, lop, ci};
  endfunction

  function automatic int adl_sum();
    int op  = int'(ab_op[4:1]);
    int ci  = int'(ab_op[0]);
    int pcl = m_pc % 256;
    int db  = int'(DB);
    int rg  = int'(REG);
    if (op >= 8) return pcl + (cond ? db : 0) + ci;
    case (op)
      0: return pcl + ci;
      1: return m_abl + ci;
      2: return db + ci;
      3: return db + rg + ci;
      4: return m_ahl + rg + ci;
      5: return rg + ci;
      6: return m_ahl + ci;
      default: return m_abl + rg + ci;
    endcase
  endfunction

  function automatic int ad_val();
    int s   = adl_sum();
    int co  = (s > 255) ? 1 : 0;
    int op  = int'(ab_op[8:5]);
    int pch = m_pc / 256;
    int h;
    case (op)
      0: h = pch + co;
      1: h = m_abh + co;
      2: h = int'(DB) + co;
      3: h = 1;
      4: h = 0;
      5: h = 255;
      6: h = pch + co + (cond ? ((m_ahl >= 128) ? 255 : 0) : 0);
      default: h = m_abh;
    endcase
    return (h % 256) * 256 + (s % 256);
  endfunction

  // Returns {out, co, v, adjh, adjl}.
  function automatic logic [11:0] alu_exp();
    int r  = int'(REG);
    int b  = alu_op[4] ? 255 - int'(M) : int'(M);
    int ci = int'(alu_ci);
    int si = int'(alu_si);
    int o = r, co = 0, v = 0, ah = 0, al = 0;
    int sr, sb, ss, hc;
    case (int'(alu_op[3:0]))
      0: begin
        o  = (r + b + ci) % 256;
        co = (r + b + ci > 255) ? 1 : 0;
        sr = (r >= 128) ? r - 256 : r;
        sb = (b >= 128) ? b - 256 : b;
        ss = sr + sb + ci;
        v  = (ss > 127 || ss < -128) ? 1 : 0;
        hc = ((r % 16) + (b % 16) + ci > 15) ? 1 : 0;
`ifdef ALU_BCD_EN
        if (alu_op[4]) begin
          al = 1 - hc;
          ah = 1 - co;
        end else begin
          al = (hc == 1 || (o % 16) > 9) ? 1 : 0;
          ah = (co == 1 || o > 153) ? 1 : 0;
        end
`endif
      end
      1: o = r | b;
      2: o = r & b;
      3: o = r ^ b;
      4: begin o = (r * 2 + si) % 256; co = (r >= 128) ? 1 : 0; end
      5: begin o = r / 2 + si * 128;   co = r % 2; end
      6: o = b;
      8: begin o = (r + 1) % 256; co = (r == 255) ? 1 : 0; end
      9: o = (r + 255) % 256;
      default: o = r;
    endcase
    return {8'(o), co[0], v[0], ah[0], al[0]};
  endfunction

  always @(posedge clk) begin
    int a;
    if (RST) begin
      m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
    end else begin
      a = ad_val();
      if (ab_op[9]) m_ahl = int'(DB);
      if (ab_op[10]) m_pc = (a + int'(ab_op[11])) % 65536;
      m_abl = a % 256;
      m_abh = a / 256;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea;
    logic [11:0] el;
    if (chk) begin
      ea = {16'(ad_val()), 16'(m_pc)};
      n_cmp++;
      if ({AD, PC} !== ea) begin
        n_bad++;
        $display("FAIL addr @%0t: AD/PC got %h/%h want %h/%h", $time, AD, PC, ea[31:16], ea[15:0]);
      end
      el = alu_exp();
      n_cmp++;
      if ({alu_out, alu_co, alu_v, adjh, adjl} !== el) begin
        n_bad++;
        $display("FAIL alu @%0t: {out,co,v,adjh,adjl} got %h want %h", $time,
                 {alu_out, alu_co, alu_v, adjh, adjl}, el);
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST = 1'b1; cond = 1'b0; DB = 8'h00; REG = 8'h00; M = 8'h00;
    alu_op = 5'b00111; alu_ci = 1'b0; alu_si = 1'b0;
    ab_op = ab(0, 0, 0, 4'b0001, 4'b0001, 0);
    step();
    chk = 1'b1;
    RST = 1'b0;
    #2;
    lit("rst_pc", PC, 16'h0000);
    lit("rst_ad", AD, 16'h0000);

    step();
    ab_op = ab(0, 0, 0, 4'b0010, 4'b0010, 0); DB = 8'h12;
    step();
    ab_op = ab(0, 0, 0, 4'b0001, 4'b0011, 0); DB = 8'hF0; REG = 8'h20;
    #2 lit("page_cross_ad", AD, 16'h1310);

    step();
    ab_op = ab(0, 1, 0, 4'b0010, 4'b0101, 0); DB = 8'h12; REG = 8'hFF;
    step();
    lit("pc_load", PC, 16'h12FF);
    ab_op = ab(1, 1, 0, 4'b0000, 4'b0000, 0);
    #2 lit("pc_inc_ad", AD, 16'h12FF);
    step();
    lit("pc_inc_wrap", PC, 16'h1300);

    ab_op = ab(0, 1, 0, 4'b0010, 4'b0101, 0); DB = 8'h20; REG = 8'h05;
    step();
    ab_op = ab(0, 0, 1, 4'b0001, 4'b0001, 0); DB = 8'hFB;
    step();
    ab_op = ab(0, 0, 0, 4'b0110, 4'b1000, 0); cond = 1'b1;
    #2 lit("branch_taken", AD, 16'h2000);
    cond = 1'b0;
    #1 lit("branch_not_taken", AD, 16'h2005);
    lit("branch_pc_hold", PC, 16'h2005);

    step();
    ab_op = ab(0, 1, 0, 4'b0010, 4'b0101, 0); DB = 8'hFF; REG = 8'hFF;
    step();
    ab_op = ab(1, 1, 0, 4'b0000, 4'b0000, 0);
    step();
    lit("pc_ffff_wrap", PC, 16'h0000);

    ab_op = ab(0, 0, 0, 4'b0001, 4'b0001, 0);
    REG = 8'h50; M = 8'h50; alu_op = 5'b00000; alu_ci = 1'b0;
    #2;
    lit("adc_out", 16'(alu_out), 16'h00A0);
    lit("adc_co", 16'(alu_co), 16'h0000);
    lit("adc_v", 16'(alu_v), 16'h0001);
`ifdef ALU_BCD_EN
    lit("adc_adjl", 16'(adjl), 16'h0000);
    lit("adc_adjh", 16'(adjh), 16'h0001);
`else
    lit("adc_adj_off", 16'({adjh, adjl}), 16'h0000);
`endif
    step();
    REG = 8'h10; M = 8'h20; alu_op = 5'b10000; alu_ci = 1'b1;
    #2;
    lit("sbc_out", 16'(alu_out), 16'h00F0);
    lit("sbc_co", 16'(alu_co), 16'h0000);
    step();
    REG = 8'h01; alu_si = 1'b1; alu_op = 5'b00101;
    #2;
    lit("ror_out", 16'(alu_out), 16'h0080);
    lit("ror_co", 16'(alu_co), 16'h0001);

    for (int i = 0; i < 3000; i++) begin
      step();
      RST    = ($urandom_range(0, 49) == 0);
      ab_op  = 12'($urandom);
      cond   = 1'($urandom);
      DB     = 8'($urandom);
      REG    = 8'($urandom);
      M      = 8'($urandom);
      alu_op = 5'($urandom);
      alu_ci = 1'($urandom);
      alu_si = 1'($urandom);
    end
    step();
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addr_alu_datapath.md
# addr_alu_datapath

Datapath slice of the 65C02 core: address-bus low/high generators, program counter, address-high latch and the 8-bit ALU in one block. The controller drives a 12-bit address op word and a 5-bit ALU op each cycle. The block produces the combinational address bus, the registered PC and the ALU result and flags. It sits between the microcode controller, the register file (REG) and the memory bus (DB).

## Interface
- No parameters.
- clk  in  1  CPU clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ab_op  in  12  bit 11 inc_pc, bit 10 ld_pc, bit 9 ld_ahl, bits 8:5 abh_op, bits 4:1 abl_op, bit 0 abl_ci.
- cond  in  1  branch condition for conditional ADL/ADH ops.
- DB  in  8  memory read data.
- REG  in  8  register-file output (index/stack/accumulator).
- M  in  8  ALU memory operand.
- alu_op  in  5  ALU function (see Operation).
- alu_ci  in  1  adder carry in.
- alu_si  in  1  shift-in bit.
- AD  out  16  address bus {ADH, ADL}, combinational.
- PC  out  16  {PCH, PCL}, registered.
- alu_out  out  8  ALU result, combinational.
- alu_co  out  1  ALU carry/shift out.
- alu_v  out  1  signed overflow.
- adjh, adjl  out  1  BCD adjust-high / adjust-low requests.

## Operation
- State: ABL, ABH (last AD), PCL, PCH, AHL (8 bits each).
- ADL by abl_op, sum 9 bits, abl_co = bit 8:
  - 0000 PCL+ci
  - 0001 ABL+ci
  - 0010 DB+ci
  - 0011 DB+REG+ci
  - 0100 AHL+REG+ci
  - 0101 REG+ci
  - 0110 AHL+ci
  - 0111 ABL+REG+ci
  - 1xxx cond ? PCL+DB+ci : PCL+ci (branch)
- ADH by abh_op, CI = abl_co:
  - 0000 PCH+CI
  - 0001 ABH+CI
  - 0010 DB+CI
  - 0011 0x01
  - 0100 0x00
  - 0101 0xFF
  - 0110 cond ? PCH+{8{AHL[7]}}+CI : PCH+CI (branch, sign-extended offset latched in AHL)
  - others ABH
- Every cycle: ABL<=ADL, ABH<=ADH. ld_ahl: AHL<=DB.
- ld_pc: PCL<=ADL+inc_pc; PCH<=ADH+(inc_pc & ADL==0xFF). Without ld_pc, PC holds; inc_pc alone is ignored.
- ALU: B = alu_op[4] ? ~M : M.
- ALU functions by alu_op[3:0]:
  - 0000 R+B+ci (ADC/SBC/CMP)
  - 0001 R|B
  - 0010 R&B
  - 0011 R^B
  - 0100 {R[6:0],si}, co=R[7]
  - 0101 {si,R[7:1]}, co=R[0]
  - 0110 B
  - 0111 R
  - 1000 R+1
  - 1001 R-1 (0xFF added, co ignored)
  - others R
- R here means REG.
- co = 0 for logic/pass ops. Adder co = carry out of bit 7.
- v = adder op 0000: (R[7]==B[7]) & (out[7]!=R[7]); else 0.
- adjl:
  - add (alu_op[4]=0): half-carry | (sum[3:0]>9).
  - subtract: ~half-carry.
- adjh:
  - add: co | (sum>0x99).
  - subtract: ~co.
- adjl and adjh are 0 for non-adder ops.

## Timing
- AD, alu_out, flags: combinational from inputs and current registers, zero latency.
- Registers update at the next rising edge; a read of AHL/ABL/PC in the same cycle as its load sees the old value.
- RST: ABL, ABH, PCL, PCH, AHL <= 0x00. AD reads 0x0000 one combinational path after reset only when the op selects register sources. RST overrides ld_pc/ld_ahl.
- Wrap-around: ADL/ADH arithmetic is modulo 256. PC 0xFFFF+1 wraps to 0x0000.

## Configuration
- ALU_BCD_EN: defined → adjh/adjl computed as above. Undefined → adjh=adjl=0 always and the BCD compare logic is removed. Binary results are identical either way.

## Test plan
- RST=1 for one edge → PC=0x0000. With abl_op=0001/abh_op=0001, AD=0x0000.
- Indexed page cross: DB=0xF0, REG=0x20, abl_op=0011, ci=0, abh_op=0001, ABH=0x12 → ADL=0x10, abl_co=1, AD=0x1310.
- PC increment wrap: PC=0x12FF, abl_op=0000, abh_op=0000, ld_pc=1, inc_pc=1 → next PC=0x1300.
- Backward branch: PC=0x2005, AHL=DB=0xFB, cond=1, abl_op=1000, abh_op=0110 → AD=0x2000. With cond=0 → AD=0x2005.
- ADC: R=0x50, M=0x50, ci=0, op=00000 → out=0xA0, co=0, v=1. With BCD: adjl=0, adjh=1.
- SBC: R=0x10, M=0x20, op=10000, ci=1 → out=0xF0, co=0. ROR R=0x01, si=1, op=00101 → out=0x80, co=1.
